// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the architectural PC and the instruction-fetch handshake. Fetches
//   the word at pc from instruction memory via imem_req/imem_ack, holds it
//   for decode, and loads next_pc when the core commits.
//
//   Ports
//     clk, reset_n             clock, async active-low reset
//     pc         (out)         architectural PC (also drives imem_addr)
//     next_pc    (in)          candidate next PC, loaded verbatim on commit
//     commit     (in)          retire current instruction (honoured in VALID)
//     imem_req   (out)         fetch request, high only in FETCH
//     imem_addr  (out)         fetch address, always equal to pc
//     imem_ack   (in)          memory data valid (honoured in FETCH)
//     imem_rdata (in)          instruction word
//     instr      (out)         registered instruction word
//     instr_valid(out)         instr holds the word fetched from pc
//     instret    (out)         committed-instruction count, wraps silently
//     fetch_fault(out)         sticky misaligned-target flag
//
//   Build option: define MISALIGN_CHECK_EN to trap commits to a target with
//   next_pc[1:0] != 0 (fetch_fault set, FSM parks in HALT until reset).
//   Without it fetch_fault is tied 0 and any target is fetched.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            commit,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [31:0]     instret,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {BOOT, FETCH, VALID, HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            vld_q, vld_d;
  logic [31:0]     instret_q, instret_d;
  logic            misalign;
  logic            commit_fire;

  // Only a commit while an instruction is held counts; elsewhere it is noise.
  assign commit_fire = (state_q == VALID) && commit;

`ifdef MISALIGN_CHECK_EN
  logic fault_q;
  assign misalign = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     fault_q <= 1'b0;
    else if (commit_fire && misalign) fault_q <= 1'b1;
  end
  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      vld_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      vld_q     <= vld_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    vld_d     = vld_q;
    instret_d = instret_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (commit_fire) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          vld_d     = 1'b0;
          // A trapped target is still architecturally loaded, just not fetched.
          state_d   = misalign ? HALT : FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    pc          = pc_q;
    instr       = instr_q;
    instr_valid = vld_q;
    instret     = instret_q;
  end

endmodule
